// File: rtl/vga_scene_ctrl_if.sv
// Scene-controller signal bundle.
//   master: board/timing side; drives keys, auto enable and vsync, and observes the scene outputs.
//   slave : vga_scene_ctrl itself.
// Signals:
//   i_key_next_n, i_key_prev_n : raw active-low push buttons (asynchronous)
//   i_auto_en                  : auto-advance enable (level)
//   i_vs                       : registered VGA vsync, active-low
//   o_scene                    : current picture index
//   o_scene_upd                : one-cycle pulse when o_scene changes
//   o_pending                  : a change request is waiting
interface vga_scene_ctrl_if #(
  parameter int SCENE_W = 2
);
  logic               i_key_next_n;
  logic               i_key_prev_n;
  logic               i_auto_en;
  logic               i_vs;
  logic [SCENE_W-1:0] o_scene;
  logic               o_scene_upd;
  logic               o_pending;

  modport master (
    output i_key_next_n, i_key_prev_n, i_auto_en, i_vs,
    input  o_scene, o_scene_upd, o_pending
  );

  modport slave (
    input  i_key_next_n, i_key_prev_n, i_auto_en, i_vs,
    output o_scene, o_scene_upd, o_pending
  );
endinterface

// File: rtl/vga_scene_ctrl.sv
// Frame-synchronous scene sequencer for the VGA path.
// Debounces next/prev buttons, optionally auto-advances every AUTO_FRAMES
// frames, and applies every picture change only on a vsync falling edge so
// no displayed frame mixes two pictures.
// Ports:
//   clk   : pixel clock (same as the VGA generator)
//   rst_n : asynchronous active-low reset
//   bus   : vga_scene_ctrl_if.slave (keys, auto enable, vsync, scene outputs)

// One key lane: 2-FF synchronizer + debounce + press pulse.
//   key_n : raw active-low key
//   press : one-cycle pulse on a debounced high->low transition
module vga_scene_ctrl_key #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic [1:0]       sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= 1'b0;
      // Any sample agreeing with the debounced level restarts the count,
      // so only an unbroken run of DB_CYCLES differing samples flips it.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        press <= ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module vga_scene_ctrl #(
  parameter int NUM_SCENES  = 2,
  parameter int SCENE_W     = 2,
  parameter int DB_CYCLES   = 500000,
  parameter int AUTO_FRAMES = 360,
  parameter int HOLD_FRAMES = 2
) (
  input logic             clk,
  input logic             rst_n,
  vga_scene_ctrl_if.slave bus
);
  localparam int NUM_KEYS = 2;
  localparam int KEY_NEXT = 0;
  localparam int KEY_PREV = 1;
  localparam int AUTO_W   = $clog2(AUTO_FRAMES + 1);
  localparam int HOLD_W   = $clog2(HOLD_FRAMES + 1);
  localparam logic [SCENE_W-1:0] LAST = SCENE_W'(NUM_SCENES - 1);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_HOLD} state_t;

  state_t state, state_nxt;

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] press;
  logic [1:0]          vs_sync;
  logic                vs_d;
  logic                tick;
  logic [AUTO_W-1:0]   auto_cnt;
  logic                auto_tick;
  logic                auto_wrap;
  logic                auto_req;
  logic                req_vld;
  logic                req_prev;   // 1: step backwards, 0: step forwards
  logic [HOLD_W-1:0]   hold_cnt;
  logic                apply;
  logic [SCENE_W-1:0]  scene;
  logic                scene_upd;

  // ---------------- key lanes ----------------
  assign key_raw[KEY_NEXT] = bus.i_key_next_n;
  assign key_raw[KEY_PREV] = bus.i_key_prev_n;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    vga_scene_ctrl_key #(.DB_CYCLES(DB_CYCLES)) u_key (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (key_raw[k]),
      .press (press[k])
    );
  end

  // ---------------- frame tick ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sync <= 2'b11;
      vs_d    <= 1'b1;
    end else begin
      vs_sync <= {vs_sync[0], bus.i_vs};
      vs_d    <= vs_sync[1];
    end
  end

  assign tick = ~vs_sync[1] & vs_d;

  // ---------------- auto-advance timer ----------------
  // Counts only while idle, so the hold and pending frames stretch the interval.
  assign auto_tick = tick && (state == S_IDLE);
  assign auto_wrap = (auto_cnt == AUTO_W'(AUTO_FRAMES - 1));
  assign auto_req  = bus.i_auto_en && auto_tick && auto_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt <= '0;
    end else if (!bus.i_auto_en || (|press)) begin
      auto_cnt <= '0;
    end else if (auto_tick) begin
      auto_cnt <= auto_wrap ? '0 : auto_cnt + 1'b1;
    end
  end

  // ---------------- request latch ----------------
  // A new press beats a clear, so a press on the applying tick survives
  // as the next request while the old direction is applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_vld  <= 1'b0;
      req_prev <= 1'b0;
    end else if (press[KEY_NEXT]) begin
      req_vld  <= 1'b1;
      req_prev <= 1'b0;
    end else if (press[KEY_PREV]) begin
      req_vld  <= 1'b1;
      req_prev <= 1'b1;
    end else if (auto_req) begin
      req_vld  <= 1'b1;
      req_prev <= 1'b0;
    end else if (apply) begin
      req_vld  <= 1'b0;
    end
  end

  // ---------------- sequencing FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    apply     = 1'b0;
    case (state)
      S_IDLE: if (req_vld) state_nxt = S_PEND;
      S_PEND: begin
        if (tick) begin
          apply     = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_cnt == '0) state_nxt = req_vld ? S_PEND : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (apply) begin
      hold_cnt <= HOLD_W'(HOLD_FRAMES);
    end else if ((state == S_HOLD) && tick && (hold_cnt != '0)) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // ---------------- scene register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scene     <= '0;
      scene_upd <= 1'b0;
    end else begin
      scene_upd <= apply;
      if (apply) begin
        if (req_prev) scene <= (scene == '0)  ? LAST : scene - 1'b1;
        else          scene <= (scene == LAST) ? '0  : scene + 1'b1;
      end
    end
  end

  assign bus.o_scene     = scene;
  assign bus.o_scene_upd = scene_upd;
  assign bus.o_pending   = req_vld;
endmodule

// File: tb/tb_vga_scene_ctrl.sv
// Self-checking bench for vga_scene_ctrl.
// The reference model works at event level: each clean press becomes a
// latch event 7 cycles after the key falls, and each latched request lands
// on the first vsync boundary that is both far enough after the latch and
// past the hold window of the previous change. Auto-advance is scheduled
// in whole frames.
module tb_vga_scene_ctrl;
  localparam int NS  = 3;
  localparam int SW  = 2;
  localparam int DB  = 4;
  localparam int AF  = 3;
  localparam int HF  = 1;
  localparam int VP  = 40;  // vsync period in cycles
  localparam int VL  = 8;   // vsync low cycles
  localparam int BND = 3;   // cycle phase at which an applied change is visible
  localparam int LAT = 2 + DB + 1; // key fall -> o_pending

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  vga_scene_ctrl_if #(.SCENE_W(SW)) bus ();

  vga_scene_ctrl #(
    .NUM_SCENES (NS),
    .SCENE_W    (SW),
    .DB_CYCLES  (DB),
    .AUTO_FRAMES(AF),
    .HOLD_FRAMES(HF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // reference model state
  int m_scene    = 0;
  bit m_vld      = 0;
  bit m_prev     = 0;
  int m_apply_at = -1;
  int m_last     = -1000;
  bit m_auto     = 0;
  int m_auto_at  = -1;
  int lat_t[$];
  bit lat_p[$];

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, act, exp);
    end
  endtask

  function automatic int boundary(input int t);
    return t + ((BND - (t % VP) + VP) % VP);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_latch(input bit prev);
    if (!m_vld) m_apply_at = boundary(imax(cyc + 2, m_last + VP * (HF + 1)));
    m_vld     = 1'b1;
    m_prev    = prev;
    m_auto_at = -1;
  endtask

  // One cycle: advance to the next negedge, drive vsync, update the model, compare.
  task automatic step();
    bit upd_exp;
    @(negedge clk);
    cyc++;
    bus.i_vs = ((cyc % VP) < VL) ? 1'b0 : 1'b1;
    upd_exp = 1'b0;
    if (m_vld && cyc == m_apply_at) begin
      m_scene = m_prev ? (m_scene + NS - 1) % NS : (m_scene + 1) % NS;
      m_vld   = 1'b0;
      m_last  = cyc;
      upd_exp = 1'b1;
      if (m_auto) m_auto_at = cyc + VP * (HF + AF);
    end
    if (lat_t.size() > 0 && lat_t[0] == cyc) begin
      model_latch(lat_p[0]);
      void'(lat_t.pop_front());
      void'(lat_p.pop_front());
    end else if (m_auto && cyc == m_auto_at) begin
      model_latch(1'b0);
    end
    chk("scene",   int'(bus.o_scene),     m_scene);
    chk("upd",     int'(bus.o_scene_upd), int'(upd_exp));
    chk("pending", int'(bus.o_pending),   int'(m_vld));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Clean press held 'hold' cycles; both keys together counts as next.
  task automatic press(input bit nx, input bit pv, input int hold);
    lat_t.push_back(cyc + LAT);
    lat_p.push_back(!nx);
    bus.i_key_next_n = !nx;
    bus.i_key_prev_n = !pv;
    run(hold);
    bus.i_key_next_n = 1'b1;
    bus.i_key_prev_n = 1'b1;
  endtask

  // Toggle a key every 2 cycles: never stable long enough to count.
  task automatic bounce(input bit use_prev);
    for (int i = 0; i < 10; i++) begin
      if (use_prev) bus.i_key_prev_n = i[0];
      else          bus.i_key_next_n = i[0];
      run(2);
    end
    bus.i_key_next_n = 1'b1;
    bus.i_key_prev_n = 1'b1;
  endtask

  task automatic set_auto(input bit en);
    bus.i_auto_en = en;
    m_auto        = en;
    m_auto_at     = en ? boundary(cyc + 1) + VP * (AF - 1) : -1;
  endtask

  // Wait until no request is outstanding and the hold window is over.
  task automatic settle();
    for (int i = 0; i < 400 && (m_vld || lat_t.size() > 0 || cyc <= m_last + VP * HF + 2); i++)
      step();
    run(2);
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < VP && (cyc % VP) != ph; i++) step();
  endtask

  initial begin
    bus.i_key_next_n = 1'b1;
    bus.i_key_prev_n = 1'b1;
    bus.i_auto_en    = 1'b0;
    bus.i_vs         = 1'b1;

    // reset state
    run(4);
    wait_phase(20);
    rst_n = 1'b1;
    run(10);

    // single press: pending exactly LAT cycles after the fall, then 0->1
    press(1, 0, 10);
    run(100);
    chk("single_press_scene", int'(bus.o_scene), 1);

    // bounce rejection
    bounce(1);
    run(60);
    chk("bounce_scene", int'(bus.o_scene), 1);

    // wrap both ways: prev, prev (1->0->2), then next, next (2->0->1)
    press(0, 1, 6); run(110);
    press(0, 1, 6); run(110);
    chk("wrap_down", int'(bus.o_scene), 2);
    press(1, 0, 6); run(110);
    chk("wrap_up", int'(bus.o_scene), 0);
    press(1, 0, 6); run(110);

    // simultaneous press -> next
    settle();
    press(1, 1, 6); run(110);

    // prev then next before the tick: one +1
    settle();
    wait_phase(4);
    press(0, 1, 5); run(8);
    press(1, 0, 5); run(120);

    // press during hold: applied one frame after the hold expires
    wait_phase(BND + 5);
    press(0, 1, 6); run(130);

    // randomized presses, bounces and gaps
    for (int it = 0; it < 24; it++) begin
      int r;
      r = $urandom_range(0, 7);
      case (r)
        0:       bounce($urandom_range(0, 1) == 1);
        1:       press(1, 1, $urandom_range(5, 12));
        2, 3, 4: press(1, 0, $urandom_range(5, 12));
        default: press(0, 1, $urandom_range(5, 12));
      endcase
      run($urandom_range(8, 130));
    end

    // auto-advance: three automatic steps, then a manual press restarts the count
    settle();
    set_auto(1);
    run(535);
    for (int i = 0; i < 300 && (cyc - m_last) != 90; i++) step();
    press(0, 1, 6);
    run(450);
    set_auto(0);
    settle();

    // reset mid-operation while a request is waiting in PEND
    for (int i = 0; i < 3 && m_scene == 0; i++) begin
      press(1, 0, 6);
      settle();
    end
    for (int i = 0; i < 200 && !((cyc % VP) == 5 && cyc > m_last + 90); i++) step();
    press(1, 0, 6);
    run(4);
    rst_n = 1'b0;
    #1;
    chk("rst_scene",   int'(bus.o_scene),     0);
    chk("rst_pending", int'(bus.o_pending),   0);
    chk("rst_upd",     int'(bus.o_scene_upd), 0);
    m_scene = 0; m_vld = 0; m_last = -1000; m_auto = 0; m_auto_at = -1;
    lat_t.delete();
    lat_p.delete();
    run(3);
    wait_phase(20);
    rst_n = 1'b1;
    run(150);
    chk("post_rst_scene", int'(bus.o_scene), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
